// File: rtl/floating_point_rounder_pkg.sv
// Shared single-precision floating-point types, rounding modes and helpers
// used by the rounding stage and its neighbours in the arithmetic pipeline.
package floating_point_rounder_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
  } float32_t;

  typedef struct packed {
    logic guard;
    logic round;
    logic sticky;
  } round_bits_t;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100
  } round_mode_e;

  localparam logic [7:0] EXP_MAX = 8'hFF;

  localparam float32_t CANONICAL_NAN = '{sign: 1'b0, exponent: EXP_MAX, mantissa: 23'h400000};

  // Infinity and NaN share the all-ones exponent and are never rounded.
  function automatic logic is_inf_or_nan(float32_t f);
    return f.exponent == EXP_MAX;
  endfunction

  // Whether the truncated magnitude must be bumped by one ulp.
  // Reserved encodings fall through to the default and truncate.
  function automatic logic round_increment(logic [2:0] mode, logic sign, logic lsb,
                                           round_bits_t rb);
    logic any_rb;
    any_rb = rb.guard | rb.round | rb.sticky;
    case (mode)
      RNE:     return rb.guard & (rb.round | rb.sticky | lsb);
      RTZ:     return 1'b0;
      RDN:     return sign & any_rb;
      RUP:     return ~sign & any_rb;
      RMM:     return rb.guard;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/floating_point_rounder.sv
// Rounds an unrounded float32 using guard/round/sticky bits; latency 2 enabled cycles.
// No backpressure: one operand per enabled cycle, clk_en_i low freezes every register.
module floating_point_rounder
  import floating_point_rounder_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clk_en_i,
  input  logic        data_valid_i,
  input  logic [31:0] operand_i,
  input  logic [2:0]  round_bits_i,
  input  logic [2:0]  round_mode_i,
  input  logic        invalid_operation_i,
  input  logic        inexact_i,
  output logic [31:0] result_o,
  output logic        data_valid_o,
  output logic        overflow_o,
  output logic        underflow_o,
  output logic        inexact_o,
  output logic        invalid_operation_o
);

  float32_t    in_op;
  round_bits_t in_rb;
  logic        in_inc;

  assign in_op = operand_i;
  assign in_rb = round_bits_i;

  // Specials and invalid results pass through unrounded, so never increment them.
  assign in_inc = ~is_inf_or_nan(in_op) & ~invalid_operation_i
                & round_increment(round_mode_i, in_op.sign, in_op.mantissa[0], in_rb);

  logic        s1_vld;
  float32_t    s1_op;
  round_bits_t s1_rb;
  logic        s1_invalid;
  logic        s1_inexact;
  logic        s1_inc;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_vld     <= 1'b0;
      s1_op      <= '0;
      s1_rb      <= '0;
      s1_invalid <= 1'b0;
      s1_inexact <= 1'b0;
      s1_inc     <= 1'b0;
    end else if (clk_en_i) begin
      s1_vld <= data_valid_i;
      if (data_valid_i) begin
        s1_op      <= in_op;
        s1_rb      <= in_rb;
        s1_invalid <= invalid_operation_i;
        s1_inexact <= inexact_i;
        s1_inc     <= in_inc;
      end
    end
  end

  // One add over {exponent, mantissa}: a mantissa carry bumps the exponent for free.
  logic [30:0] sum;
  logic        sum_ovf;

  assign sum     = {s1_op.exponent, s1_op.mantissa} + {30'd0, s1_inc};
  assign sum_ovf = (sum[30:23] == EXP_MAX);

  float32_t nxt_result;
  logic     nxt_ovf;
  logic     nxt_unf;
  logic     nxt_inx;

  always_comb begin
    nxt_result = s1_op;
    nxt_ovf    = 1'b0;
    nxt_unf    = 1'b0;
    nxt_inx    = 1'b0;
    if (s1_invalid || is_inf_or_nan(s1_op)) begin
      nxt_result = s1_op;
    end else if (sum_ovf) begin
      nxt_result = '{sign: s1_op.sign, exponent: EXP_MAX, mantissa: 23'd0};
      nxt_ovf    = 1'b1;
      nxt_inx    = 1'b1;
    end else begin
      nxt_result = {s1_op.sign, sum};
      nxt_inx    = s1_rb.guard | s1_rb.round | s1_rb.sticky | s1_inexact;
      // Tininess is judged after rounding.
      nxt_unf    = (sum[30:23] == 8'd0) & nxt_inx;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_valid_o        <= 1'b0;
      result_o            <= '0;
      overflow_o          <= 1'b0;
      underflow_o         <= 1'b0;
      inexact_o           <= 1'b0;
      invalid_operation_o <= 1'b0;
    end else if (clk_en_i) begin
      data_valid_o <= s1_vld;
      if (s1_vld) begin
        result_o            <= nxt_result;
        overflow_o          <= nxt_ovf;
        underflow_o         <= nxt_unf;
        inexact_o           <= nxt_inx;
        invalid_operation_o <= s1_invalid;
      end
    end
  end

endmodule

// File: tb/tb_floating_point_rounder.sv
// Bench for floating_point_rounder: directed corner vectors plus a randomized
// stream with random stalls, scored against a magnitude-level rounding model.
module tb_floating_point_rounder;
  import floating_point_rounder_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic        vld_in;
  logic [31:0] operand;
  logic [2:0]  round_bits;
  logic [2:0]  round_mode;
  logic        invalid_in;
  logic        inexact_in;
  logic [31:0] result;
  logic        vld_out;
  logic        overflow;
  logic        underflow;
  logic        inexact_out;
  logic        invalid_out;

  logic [35:0] obs;
  assign obs = {result, overflow, underflow, inexact_out, invalid_out};

  int total = 0;
  int bad   = 0;

  floating_point_rounder dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .clk_en_i            (clk_en),
    .data_valid_i        (vld_in),
    .operand_i           (operand),
    .round_bits_i        (round_bits),
    .round_mode_i        (round_mode),
    .invalid_operation_i (invalid_in),
    .inexact_i           (inexact_in),
    .result_o            (result),
    .data_valid_o        (vld_out),
    .overflow_o          (overflow),
    .underflow_o         (underflow),
    .inexact_o           (inexact_out),
    .invalid_operation_o (invalid_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] op;
    logic [2:0]  rb;
    logic [2:0]  mode;
    logic        inv;
    logic [35:0] want;
  } vec_t;

  vec_t        vecs [12];
  logic [35:0] sb [$];

  // Reference: decide by comparing the discarded fraction against half an ulp,
  // then judge the resulting magnitude against the infinity/normal thresholds.
  function automatic logic [35:0] ref_round(logic [31:0] op, logic [2:0] rb, logic [2:0] mode,
                                            logic inv, logic inx_in);
    logic        sign, g, r, s, nonzero, above_half, at_half, up, inx;
    logic [31:0] mag, newmag;
    sign       = op[31];
    mag        = {1'b0, op[30:0]};
    g          = rb[2];
    r          = rb[1];
    s          = rb[0];
    nonzero    = g || r || s;
    above_half = g && (r || s);
    at_half    = g && !r && !s;
    case (mode)
      3'd0:    up = above_half || (at_half && mag[0]);
      3'd2:    up = sign && nonzero;
      3'd3:    up = !sign && nonzero;
      3'd4:    up = g;
      default: up = 1'b0;
    endcase
    if (inv) return {op, 4'b0001};
    if (mag >= 32'h7F80_0000) return {op, 4'b0000};
    newmag = mag + {31'd0, up};
    if (newmag >= 32'h7F80_0000) return {sign, 31'h7F80_0000, 4'b1010};
    inx = nonzero || inx_in;
    return {sign, newmag[30:0], 1'b0, (newmag < 32'h0080_0000) && inx, inx, 1'b0};
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [31:0] sel, e, m;
    sel = $urandom_range(0, 6);
    e   = $urandom;
    m   = $urandom;
    case (sel)
      0: e = 32'h00;
      1: e = 32'hFE;
      2: e = 32'hFF;
      3: e = 32'h01;
      default: ;
    endcase
    if ($urandom_range(0, 3) == 0) m = 32'h007F_FFFF;
    return {m[31], e[7:0], m[22:0]};
  endfunction

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(logic [31:0] op, logic [2:0] rb, logic [2:0] mode, logic inv, logic inx);
    vld_in     = 1'b1;
    operand    = op;
    round_bits = rb;
    round_mode = mode;
    invalid_in = inv;
    inexact_in = inx;
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    clk_en = 1'b0;
    vld_in = 1'b0;
    cycle();
    cycle();
    total++;
    if ({vld_out, obs} !== 37'd0) begin
      bad++;
      $display("FAIL reset_state: got %h want 0", {vld_out, obs});
    end
    rst    = 1'b0;
    clk_en = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] nan;
    nan = CANONICAL_NAN;
    vecs[0]  = '{32'h3F80_0000, 3'b100, RNE,    1'b0, {32'h3F80_0000, 4'b0010}};
    vecs[1]  = '{32'h3F80_0001, 3'b100, RNE,    1'b0, {32'h3F80_0002, 4'b0010}};
    vecs[2]  = '{32'h3FFF_FFFF, 3'b100, RUP,    1'b0, {32'h4000_0000, 4'b0010}};
    vecs[3]  = '{32'h7F7F_FFFF, 3'b110, RNE,    1'b0, {32'h7F80_0000, 4'b1010}};
    vecs[4]  = '{32'h7F7F_FFFF, 3'b110, RTZ,    1'b0, {32'h7F7F_FFFF, 4'b0010}};
    vecs[5]  = '{nan,           3'b111, RNE,    1'b0, {32'h7FC0_0000, 4'b0000}};
    vecs[6]  = '{32'h807F_FFFF, 3'b100, RDN,    1'b0, {32'h8080_0000, 4'b0010}};
    vecs[7]  = '{32'h0000_0001, 3'b001, RNE,    1'b0, {32'h0000_0001, 4'b0110}};
    vecs[8]  = '{32'h3F80_0001, 3'b111, RUP,    1'b1, {32'h3F80_0001, 4'b0001}};
    vecs[9]  = '{32'h3F80_0000, 3'b111, 3'b101, 1'b0, {32'h3F80_0000, 4'b0010}};
    vecs[10] = '{32'h3F80_0000, 3'b100, RMM,    1'b0, {32'h3F80_0001, 4'b0010}};
    vecs[11] = '{32'h3F80_0000, 3'b001, RDN,    1'b0, {32'h3F80_0000, 4'b0010}};
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].op, vecs[i].rb, vecs[i].mode, vecs[i].inv, 1'b0);
      cycle();
      vld_in = 1'b0;
      total++;
      if (vld_out !== 1'b0) begin
        bad++;
        $display("FAIL directed_early_valid[%0d]: got %b want 0", i, vld_out);
      end
      cycle();
      total++;
      if ({vld_out, obs} !== {1'b1, vecs[i].want}) begin
        bad++;
        $display("FAIL directed[%0d]: got vld=%b %h want vld=1 %h", i, vld_out, obs, vecs[i].want);
      end
    end
  endtask

  task automatic test_random();
    logic        last_en;
    logic [35:0] want;
    logic [31:0] op;
    logic [2:0]  rb, mode;
    logic        inv, inx;
    last_en = 1'b0;
    for (int i = 0; i < 603; i++) begin
      if (last_en && vld_out) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL random_extra_pulse: got %h want no pulse", obs);
        end else begin
          want = sb.pop_front();
          if (obs !== want) begin
            bad++;
            $display("FAIL random_result: got %h want %h", obs, want);
          end
        end
      end
      op   = rand_operand();
      rb   = 3'($urandom_range(0, 7));
      mode = 3'($urandom_range(0, 7));
      inv  = ($urandom_range(0, 15) == 0);
      inx  = ($urandom_range(0, 3) == 0);
      drive(op, rb, mode, inv, inx);
      vld_in = ($urandom_range(0, 4) != 0);
      clk_en = ($urandom_range(0, 3) != 0);
      if (i >= 600) begin
        vld_in = 1'b0;
        clk_en = 1'b1;
      end
      if (clk_en && vld_in) sb.push_back(ref_round(op, rb, mode, inv, inx));
      last_en = clk_en;
      cycle();
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL random_missing_pulses: got %0d left want 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_back_to_back_stall();
    logic [31:0] ops [3];
    logic [35:0] exp_q [3];
    for (int i = 0; i < 3; i++) begin
      ops[i]   = rand_operand();
      exp_q[i] = ref_round(ops[i], 3'b110, RNE, 1'b0, 1'b0);
    end
    clk_en = 1'b1;
    drive(ops[0], 3'b110, RNE, 1'b0, 1'b0);
    cycle();
    drive(ops[1], 3'b110, RNE, 1'b0, 1'b0);
    cycle();
    total++;
    if ({vld_out, obs} !== {1'b1, exp_q[0]}) begin
      bad++;
      $display("FAIL stall_first: got vld=%b %h want vld=1 %h", vld_out, obs, exp_q[0]);
    end
    drive(ops[2], 3'b110, RNE, 1'b0, 1'b0);
    clk_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      total++;
      if ({vld_out, obs} !== {1'b1, exp_q[0]}) begin
        bad++;
        $display("FAIL stall_frozen[%0d]: got vld=%b %h want vld=1 %h", i, vld_out, obs, exp_q[0]);
      end
    end
    clk_en = 1'b1;
    cycle();
    vld_in = 1'b0;
    for (int i = 1; i < 3; i++) begin
      total++;
      if ({vld_out, obs} !== {1'b1, exp_q[i]}) begin
        bad++;
        $display("FAIL stall_resume[%0d]: got vld=%b %h want vld=1 %h", i, vld_out, obs, exp_q[i]);
      end
      cycle();
    end
    total++;
    if (vld_out !== 1'b0) begin
      bad++;
      $display("FAIL stall_tail: got vld=%b want 0", vld_out);
    end
  endtask

  task automatic test_reset_in_flight();
    clk_en = 1'b1;
    drive(32'h3F80_0001, 3'b100, RNE, 1'b0, 1'b0);
    cycle();
    vld_in = 1'b0;
    rst    = 1'b1;
    clk_en = 1'b0;
    cycle();
    total++;
    if ({vld_out, obs} !== 37'd0) begin
      bad++;
      $display("FAIL reset_flush: got %h want 0", {vld_out, obs});
    end
    rst    = 1'b0;
    clk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      total++;
      if (vld_out !== 1'b0) begin
        bad++;
        $display("FAIL reset_stale_pulse[%0d]: got vld=%b want 0", i, vld_out);
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    clk_en     = 1'b0;
    vld_in     = 1'b0;
    operand    = '0;
    round_bits = '0;
    round_mode = '0;
    invalid_in = 1'b0;
    inexact_in = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back_stall();
    test_reset_in_flight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
